// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matmul tile accumulator: FSM state encoding,
// accumulator width and the halved-precision operand select.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    function automatic int acc_width(input int p);
        return 4 * p;
    endfunction

    // Sign-extends the low p (full) or p/2 (halved) bits of value to 64 bits.
    function automatic logic signed [63:0] operand_select(input logic [63:0] value,
                                                          input int p,
                                                          input logic halved);
        int sh;
        sh = 64 - (halved ? p / 2 : p);
        return $signed(value << sh) >>> sh;
    endfunction

endpackage

// File: rtl/matmul_tile_accumulator_if.sv
// Job configuration, tile stream and result handshakes of the tile accumulator.
interface matmul_tile_accumulator_if
    import matmul_pkg::*;
#(
    parameter int M       = 2,
    parameter int N       = 2,
    parameter int K       = 2,
    parameter int P       = 8,
    parameter int TILES_W = 16
);
    localparam int AW = acc_width(P);

    logic                          cfg_valid;
    logic                          cfg_ready;
    logic [TILES_W-1:0]            cfg_num_tiles;
    logic                          cfg_halved;
    logic [M-1:0][N-1:0][AW-1:0]   C;
    logic                          in_valid;
    logic                          in_ready;
    logic [M-1:0][K-1:0][P-1:0]    A;
    logic [K-1:0][N-1:0][P-1:0]    B;
    logic                          d_valid;
    logic                          d_ready;
    logic [M-1:0][N-1:0][AW-1:0]   D;
    logic                          busy;

    modport master (
        output cfg_valid, cfg_num_tiles, cfg_halved, C, in_valid, A, B, d_ready,
        input  cfg_ready, in_ready, d_valid, D, busy
    );

    modport slave (
        input  cfg_valid, cfg_num_tiles, cfg_halved, C, in_valid, A, B, d_ready,
        output cfg_ready, in_ready, d_valid, D, busy
    );

endinterface

// File: rtl/matmul_tile_datapath.sv
// Combinational M x N x K dot-product array; products and sums wrap to the
// accumulator width.
module matmul_tile_datapath
    import matmul_pkg::*;
#(
    parameter int M = 2,
    parameter int N = 2,
    parameter int K = 2,
    parameter int P = 8
) (
    input  logic                                 halved,
    input  logic [M-1:0][K-1:0][P-1:0]           a,
    input  logic [K-1:0][N-1:0][P-1:0]           b,
    output logic [M-1:0][N-1:0][acc_width(P)-1:0] s
);
    localparam int AW = acc_width(P);

    logic signed [63:0] a_op;
    logic signed [63:0] b_op;
    logic [AW-1:0]      prod;
    logic [AW-1:0]      sum;

    always_comb begin
        s    = '0;
        a_op = '0;
        b_op = '0;
        prod = '0;
        sum  = '0;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                sum = '0;
                for (int k = 0; k < K; k++) begin
                    a_op = operand_select(64'(a[i][k]), P, halved);
                    b_op = operand_select(64'(b[k][j]), P, halved);
                    prod = AW'(a_op * b_op);
                    sum  = sum + prod;
                end
                s[i][j] = sum;
            end
        end
    end

endmodule

// File: rtl/matmul_tile_accumulator.sv
// Multi-tile matrix multiply-accumulate: D = C + sum_t A_t * B_t, one tile per
// cycle through a product stage and an accumulate stage.
//
// state | meaning
// IDLE  | waiting for a job; cfg_ready high, D forced to zero
// ACCUM | accepting tiles and folding stage-1 partial sums into acc
// DONE  | result presented on D until d_valid && d_ready
module matmul_tile_accumulator
    import matmul_pkg::*;
#(
    parameter int M       = 2,
    parameter int N       = 2,
    parameter int K       = 2,
    parameter int P       = 8,
    parameter int TILES_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    matmul_tile_accumulator_if.slave  bus
);
    localparam int AW = acc_width(P);

    state_t                       state, state_nxt;
    logic [M-1:0][N-1:0][AW-1:0]  acc;
    logic [M-1:0][N-1:0][AW-1:0]  s_comb;
    logic [M-1:0][N-1:0][AW-1:0]  s1;
    logic                         s1_valid;
    logic [TILES_W-1:0]           num_tiles;
    logic [TILES_W-1:0]           accepted;
    logic [TILES_W-1:0]           accumulated;
    logic                         halved_q;
    logic                         in_hs;
    logic                         last_acc;

    matmul_tile_datapath #(.M(M), .N(N), .K(K), .P(P)) u_datapath (
        .halved (halved_q),
        .a      (bus.A),
        .b      (bus.B),
        .s      (s_comb)
    );

    assign in_hs    = bus.in_valid && bus.in_ready;
    assign last_acc = s1_valid && ((accumulated + TILES_W'(1)) == num_tiles);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.cfg_ready = 1'b0;
        bus.in_ready  = 1'b0;
        bus.d_valid   = 1'b0;
        bus.busy      = 1'b1;
        bus.D         = '0;
        case (state)
            IDLE: begin
                bus.cfg_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.cfg_valid)
                    state_nxt = (bus.cfg_num_tiles == '0) ? DONE : ACCUM;
            end
            ACCUM: begin
                bus.in_ready = (accepted < num_tiles);
                if (last_acc) state_nxt = DONE;
            end
            DONE: begin
                bus.d_valid = 1'b1;
                bus.D       = acc;
                if (bus.d_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // acc survives the DONE->IDLE handshake; only a new job or reset overwrites it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc         <= '0;
            s1          <= '0;
            s1_valid    <= 1'b0;
            num_tiles   <= '0;
            accepted    <= '0;
            accumulated <= '0;
            halved_q    <= 1'b0;
        end else begin
            s1_valid <= in_hs;
            if (state == IDLE && bus.cfg_valid) begin
                acc         <= bus.C;
                num_tiles   <= bus.cfg_num_tiles;
                halved_q    <= bus.cfg_halved;
                accepted    <= '0;
                accumulated <= '0;
            end
            if (in_hs) begin
                s1       <= s_comb;
                accepted <= accepted + TILES_W'(1);
            end
            if (state == ACCUM && s1_valid) begin
                for (int i = 0; i < M; i++)
                    for (int j = 0; j < N; j++)
                        acc[i][j] <= acc[i][j] + s1[i][j];
                accumulated <= accumulated + TILES_W'(1);
            end
        end
    end

endmodule

// File: doc/matmul_tile_accumulator.md
Name: matmul_tile_accumulator

Overview:
- Sequential, handshaked successor to the combinational matrix multiply-accumulate datapath.
- Accumulates a runtime-configured number of K-tiles into an internal M×N accumulator seeded from C: D = C + Σ_t A_t·B_t.
- Per-job precision mode: full or halved operand precision.
- Sits between the operand streamers and the writeback unit of the accelerator tile.

Parameters:
- M, 2: rows of A, C and D.
- N, 2: columns of B, C and D.
- K, 2: inner dimension of one tile.
- P, 8: operand width in bits; must be even and at least 4.
- TILES_W, 16: width of the tile-count field.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  job-start request.
- cfg_ready  out  1  accepting a job; high only in IDLE.
- cfg_num_tiles  in  TILES_W  number of A/B tiles in the job; 0 is allowed.
- cfg_halved  in  1  halved-precision mode for the job.
- C  in  [M][N]×4P signed  accumulator seed.
- in_valid  in  1  A/B tile valid.
- in_ready  out  1  tile accepted when in_valid && in_ready.
- A  in  [M][K]×P signed  tile operand.
- B  in  [K][N]×P signed  tile operand.
- d_valid  out  1  result valid.
- d_ready  in  1  result consumed.
- D  out  [M][N]×4P signed  result.
- busy  out  1  high when not in IDLE.

Behaviour:
- States: IDLE, ACCUM, DONE.
- Reset: state=IDLE, accumulator=0, tile counters=0, pipeline valid=0, d_valid=0, in_ready=0, D=0, busy=0, cfg_ready=1.
- IDLE:
  - On cfg_valid: latch C into the accumulator, latch cfg_num_tiles, latch cfg_halved.
  - Go to DONE if cfg_num_tiles==0; otherwise go to ACCUM.
  - Values on cfg_* and C are ignored outside IDLE.
- ACCUM, accept side:
  - in_ready=1 while accepted < num_tiles.
  - Each handshake registers the tile partial sum S[i][j] = Σ_k A[i][k]·B[k][j] into stage 1 (s1_valid=1) and increments the accepted counter.
- ACCUM, accumulate side: when s1_valid, stage 2 does acc += S and increments the accumulated counter.
- ACCUM exit: go to DONE in the cycle the final tile is accumulated.
- Latency: d_valid rises 2 cycles after the final tile handshake.
- Input gaps: when in_valid=0, no accumulation and no counter change.
- Back-to-back tiles: one tile per cycle is sustained.
- DONE:
  - d_valid=1 and D=accumulator; D is held stable until d_valid && d_ready.
  - On that handshake: go to IDLE, accumulator is kept (not cleared).
  - Next job start: cfg_ready is high the cycle after the handshake.
  - No overlap between jobs.
- Arithmetic:
  - Products are full 2P-bit signed, sign-extended to 4P.
  - All sums wrap modulo 2^(4P); no saturation, no overflow flag.
- Halved mode: each operand is replaced by the sign extension of its low P/2 bits before multiplying. Upper bits are ignored.
- Reset mid-operation: job aborted immediately; no d_valid for the aborted job.
- D port: driven by the accumulator only in DONE; 0 otherwise.

Decomposition:
- Package matmul_pkg holds:
  - state enum (IDLE, ACCUM, DONE);
  - function acc_width(P)=4P;
  - function operand_select(value, halved) for the sign-extension rule.
- One sub-module, matmul_tile_datapath: combinational M×N×K dot-product array with halved-mode operand select, producing S.
- The top level holds the FSM, counters, stage-1 register and accumulator.

Test Plan (M=N=K=2, P=8):
- 1 tile, C=0, A=[[1,2],[3,4]], B=[[5,6],[7,8]] → D=[[19,22],[43,50]]; d_valid exactly 2 cycles after the tile handshake.
- 2 tiles, both the tile above, C=all 1 → D=[[39,45],[87,101]]; random in_valid gaps give the same result and same tile count.
- num_tiles=0, C=[[5,-5],[7,0]] → d_valid the cycle after cfg handshake; D=C; in_ready never high.
- A=all 8'hF3, B=all 8'h0E, 1 tile, C=0: full precision → every D=-364; halved → every D=-12.
- d_ready held low 5 cycles in DONE → D and d_valid stable, cfg_ready=0, cfg_valid ignored; cfg_ready=1 the cycle after the d handshake.
- rst pulsed after 1 of 3 tiles → outputs at reset values, no d_valid; the following 1-tile job from the first scenario → D=[[19,22],[43,50]].
